ir_assembler: RTL
=================

// Module: ir_assembler
// PURPOSE
//  Parametrised instruction register. Assembles a BEATS-beat instruction from a
//  narrow data bus, MS beat first, and splits it into opcode and address fields.
//  Sits between the memory data bus and the controller, replacing the fixed
//  2-beat 8-bit IR. Fields update atomically, and a valid/ack handshake tells the
//  controller when a complete instruction is present.
// PARAMETERS
//  BUS_W   8  data bus width in bits, >=1
//  BEATS   2  bus beats per instruction, >=1; INSTR_W = BUS_W*BEATS (localparam)
//  OP_W    3  opcode width, 1..INSTR_W-1; ADDR_W = INSTR_W-OP_W (localparam)
// PORTS
//  clk_ctrl     in   1        clock; all state changes on its rising edge
//  reset        in   1        asynchronous, active-high reset
//  load_ir      in   1        beat strobe; data_bus is captured while high
//  data_bus     in   BUS_W    instruction beat
//  instr_ack    in   1        controller has consumed the current instruction
//  opcode       out  OP_W     instruction bits [INSTR_W-1 -: OP_W]
//  addr_ir      out  ADDR_W   instruction bits [ADDR_W-1:0]
//  instr_valid  out  1        a complete instruction is held in opcode/addr_ir
//  busy         out  1        a partial instruction is in progress (beat_cnt != 0)
//  fetch_abort  out  1        one-cycle pulse: partial fetch discarded
//  overrun      out  1        one-cycle pulse: beat dropped because the IR is full
// BEHAVIOUR
//  - Reset (asynchronous) clears opcode, addr_ir, instr_valid, busy, fetch_abort,
//    overrun, beat_cnt and the shadow register to 0.
//  - State = {full, beat_cnt}, beat_cnt in 0..BEATS-1. beat 0 = MS BUS_W bits.
//  - Not full and load_ir=1: data_bus goes into shadow slot beat_cnt, and beat_cnt
//    increments. On the last beat (beat_cnt==BEATS-1), the next edge loads
//    {shadow,data_bus} into opcode/addr_ir, sets instr_valid=1 and sets
//    beat_cnt=0. Latency: fields are valid 1 cycle after the last beat.
//  - opcode/addr_ir never show partial data. They change only on completion or
//    on reset.
//  - Not full, load_ir=0, beat_cnt!=0: beat_cnt returns to 0, the shadow is
//    discarded and fetch_abort=1 for 1 cycle. With beat_cnt==0 this is a no-op.
//  - Full: instr_valid stays high until instr_ack is sampled high, then it clears
//    on that edge. opcode/addr_ir keep their value after the ack.
//  - Full, load_ir=1, instr_ack=0: the beat is dropped, overrun=1 for 1 cycle and
//    the held instruction is unchanged.
//  - Full, load_ir=1, instr_ack=1 (same cycle): the ack is honoured and the beat
//    is captured as beat 0. If BEATS==1, the new instruction loads and
//    instr_valid stays 1.
//  - instr_ack while not full is ignored. load_ir=0 while full does not abort.
//  - BEATS==1: every load_ir beat (when accepted) completes an instruction.
//    busy is always 0.
//  - Reset mid-fetch discards all beats immediately. There is no pulse on
//    fetch_abort.
// CONFIGURATION
//  IR_PARITY_EN defined:
//   - Adds input data_par (1 bit, even parity over data_bus) and output par_err
//     (reset 0).
//   - A captured beat with odd parity over {data_par,data_bus} aborts the fetch:
//     beat_cnt=0, shadow discarded, no completion, par_err=1 for 1 cycle.
//     fetch_abort is not asserted.
//  IR_PARITY_EN undefined: no parity ports or logic. Every accepted beat is
//   captured.
// TESTING
//  1 Defaults: load_ir=1 for 2 cycles with 8'hA5, 8'h3C -> 1 cycle later
//    opcode=3'b101, addr_ir=13'h053C, instr_valid=1. busy=1 only after beat 0.
//  2 Abort: load_ir 1 cycle (8'hFF), then 0 -> fetch_abort pulses once,
//    opcode/addr_ir keep their old value, the next 2 beats assemble normally.
//  3 Overrun: complete an instruction, no ack, load_ir=1 with 8'h11 -> overrun
//    pulses once and addr_ir is unchanged. Then instr_ack=1 -> instr_valid=0
//    next edge.
//  4 Ack+load same cycle: BEATS=1, BUS_W=16, OP_W=4, back-to-back loads
//    16'h1234, 16'hABCD with instr_ack=1 -> opcode 1 then A, instr_valid
//    constantly 1.
//  5 Async reset mid-fetch after beat 0 -> all outputs 0 with no clock edge.
//    A fresh 2-beat fetch then completes correctly.
//  6 IR_PARITY_EN: beat 0 with wrong data_par -> par_err pulse, busy=0,
//    no instr_valid.

Source files
------------

// File: rtl/ir_assembler.sv
// ir_assembler: parametrised instruction register.
// Collects BEATS bus beats into one instruction, most significant beat first.
// It publishes the opcode and address fields together when the last beat arrives.
// A valid/ack handshake with the controller marks when the register is full.
// Optional feature: define IR_PARITY_EN to add the data_par input and the
// par_err output. This enables per-beat even-parity checking.
module ir_assembler #(
    parameter int BUS_W = 8,
    parameter int BEATS = 2,
    parameter int OP_W  = 3
) (
    input  logic                               clk_ctrl,
    input  logic                               reset,
    input  logic                               load_ir,
    input  logic [BUS_W-1:0]                   data_bus,
    input  logic                               instr_ack,
`ifdef IR_PARITY_EN
    input  logic                               data_par,
    output logic                               par_err,
`endif
    output logic [OP_W-1:0]                    opcode,
    output logic [BUS_W*BEATS-OP_W-1:0]        addr_ir,
    output logic                               instr_valid,
    output logic                               busy,
    output logic                               fetch_abort,
    output logic                               overrun
);

    localparam int INSTR_W = BUS_W * BEATS;
    localparam int ADDR_W  = INSTR_W - OP_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic               full_q,   full_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [INSTR_W-1:0] shadow_q, shadow_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic               abort_q,  abort_d;
    logic               ovr_q,    ovr_d;
    logic               perr_q,   perr_d;

    logic               accept;
    logic               beat_ok;
    logic [INSTR_W-1:0] slot_w;
    int                 slot_lsb;

    // Next-state logic: beat capture, completion, abort, overrun and ack handling
    always_comb begin
        full_d   = full_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        abort_d  = 1'b0;
        ovr_d    = 1'b0;
        perr_d   = 1'b0;
        slot_w   = shadow_q;
        slot_lsb = (BEATS - 1 - int'(cnt_q)) * BUS_W;
`ifdef IR_PARITY_EN
        beat_ok  = ~^{data_par, data_bus};
`else
        beat_ok  = 1'b1;
`endif
        // An ack in the same cycle frees the register, so that beat can be taken.
        accept   = load_ir && (!full_q || instr_ack);

        if (full_q && instr_ack) begin
            full_d = 1'b0;
        end

        if (load_ir && full_q && !instr_ack) begin
            ovr_d = 1'b1;
        end

        if (accept) begin
            if (!beat_ok) begin
                cnt_d  = '0;
                perr_d = 1'b1;
            end else begin
                slot_w[slot_lsb +: BUS_W] = data_bus;
                if (cnt_q == LAST_BEAT) begin
                    opcode_d = slot_w[INSTR_W-1 -: OP_W];
                    addr_d   = slot_w[ADDR_W-1:0];
                    full_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    shadow_d = slot_w;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
        end else if (!load_ir && !full_q && (cnt_q != '0)) begin
            // A gap in the beat stream throws away the partial instruction.
            // Stale shadow slots are harmless because each slot is rewritten before use.
            cnt_d   = '0;
            abort_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            full_q   <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
            opcode_q <= '0;
            addr_q   <= '0;
            abort_q  <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            full_q   <= full_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            abort_q  <= abort_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
        end
    end

    assign opcode      = opcode_q;
    assign addr_ir     = addr_q;
    assign instr_valid = full_q;
    assign busy        = (cnt_q != '0);
    assign fetch_abort = abort_q;
    assign overrun     = ovr_q;
`ifdef IR_PARITY_EN
    assign par_err     = perr_q;
`endif

endmodule
